// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both requester ports and the data-memory port of the arbiter.
// The arbiter connects through the slave modport and the requester/memory side through the master modport.
interface dmem_port_arbiter_if;
  logic        rq0_req;
  logic        rq0_wr;
  logic        rq0_lock;
  logic [31:0] rq0_addr;
  logic [63:0] rq0_wdata;
  logic        rq0_gnt;
  logic        rq0_rvalid;
  logic [63:0] rq0_rdata;

  logic        rq1_req;
  logic        rq1_wr;
  logic        rq1_lock;
  logic [31:0] rq1_addr;
  logic [63:0] rq1_wdata;
  logic        rq1_gnt;
  logic        rq1_rvalid;
  logic [63:0] rq1_rdata;

  logic        mem_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  rq0_req, rq0_wr, rq0_lock, rq0_addr, rq0_wdata,
    output rq0_gnt, rq0_rvalid, rq0_rdata,
    input  rq1_req, rq1_wr, rq1_lock, rq1_addr, rq1_wdata,
    output rq1_gnt, rq1_rvalid, rq1_rdata,
    output mem_en, mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output rq0_req, rq0_wr, rq0_lock, rq0_addr, rq0_wdata,
    input  rq0_gnt, rq0_rvalid, rq0_rdata,
    output rq1_req, rq1_wr, rq1_lock, rq1_addr, rq1_wdata,
    input  rq1_gnt, rq1_rvalid, rq1_rdata,
    input  mem_en, mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester data-memory arbiter: combinational round-robin grant with optional
// exclusive locking, plus a read-tag pipeline that steers returning read data to its owner.
module dmem_port_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  state_t  state;
  state_t  state_next;
  logic    last_gnt;
  logic    gnt0;
  logic    gnt1;
  rd_tag_t rd_push;
  rd_tag_t rd_out;
  rd_tag_t rd_pipe [RD_LATENCY];

  // NOTE: reset is synchronous, so it is sampled like any other input and stays out of the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= OPEN;
      last_gnt <= 1'b1;
    end else begin
      state <= state_next;
      if (gnt0 || gnt1) last_gnt <= gnt1;
    end
  end

  // NOTE: every signal written in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      OPEN: begin
        if (gnt0 && bus.rq0_lock)      state_next = LOCK0;
        else if (gnt1 && bus.rq1_lock) state_next = LOCK1;
      end
      LOCK0:   if (gnt0 && !bus.rq0_lock) state_next = OPEN;
      LOCK1:   if (gnt1 && !bus.rq1_lock) state_next = OPEN;
      default: state_next = OPEN;
    endcase
  end

  // Grants are gated by reset so nothing reaches memory while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      unique case (state)
        OPEN: begin
          if (bus.rq0_req && bus.rq1_req) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
          end else begin
            gnt0 = bus.rq0_req;
            gnt1 = bus.rq1_req;
          end
        end
        LOCK0:   gnt0 = bus.rq0_req;
        LOCK1:   gnt1 = bus.rq1_req;
        default: ;
      endcase
    end
  end

  assign bus.rq0_gnt = gnt0;
  assign bus.rq1_gnt = gnt1;

  always_comb begin
    bus.mem_en    = gnt0 || gnt1;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt0) begin
      bus.mem_wr_en = bus.rq0_wr;
      bus.mem_addr  = bus.rq0_addr;
      bus.mem_wdata = bus.rq0_wdata;
    end else if (gnt1) begin
      bus.mem_wr_en = bus.rq1_wr;
      bus.mem_addr  = bus.rq1_addr;
      bus.mem_wdata = bus.rq1_wdata;
    end
  end

  always_comb begin
    rd_push.valid = (gnt0 && !bus.rq0_wr) || (gnt1 && !bus.rq1_wr);
    rd_push.owner = gnt1;
  end

  // NOTE: the tag pipeline is reset (unlike a data RAM) because a stale valid tag would emit a spurious rvalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= rd_push;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rd_out = rd_pipe[RD_LATENCY-1];

  always_comb begin
    bus.rq0_rvalid = reset && rd_out.valid && !rd_out.owner;
    bus.rq1_rvalid = reset && rd_out.valid &&  rd_out.owner;
    bus.rq0_rdata  = bus.rq0_rvalid ? bus.mem_rdata : '0;
    bus.rq1_rdata  = bus.rq1_rvalid ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a cycle-by-cycle vector table on an RD_LATENCY=2
// instance, then a mid-operation reset sequence shared with an RD_LATENCY=3 instance.
module tb_dmem_port_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_port_arbiter_if bus_a ();
  dmem_port_arbiter_if bus_b ();

  dmem_port_arbiter #(.RD_LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  dmem_port_arbiter #(.RD_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, w0, l0;
    logic [31:0] a0;
    logic [63:0] d0;
    logic        r1, w1, l1;
    logic [31:0] a1;
    logic [63:0] d1;
    logic [63:0] mrd;
    logic        g0, g1, men, mwr;
    logic [31:0] maddr;
    logic [63:0] mwd;
    logic        v0, v1;
    logic [63:0] rd0, rd1;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.rq0_req = L; bus_a.rq0_wr = L; bus_a.rq0_lock = L; bus_a.rq0_addr = '0; bus_a.rq0_wdata = '0;
    bus_a.rq1_req = L; bus_a.rq1_wr = L; bus_a.rq1_lock = L; bus_a.rq1_addr = '0; bus_a.rq1_wdata = '0;
    bus_a.mem_rdata = '0;
  endtask

  task automatic idle_b();
    bus_b.rq0_req = L; bus_b.rq0_wr = L; bus_b.rq0_lock = L; bus_b.rq0_addr = '0; bus_b.rq0_wdata = '0;
    bus_b.rq1_req = L; bus_b.rq1_wr = L; bus_b.rq1_lock = L; bus_b.rq1_addr = '0; bus_b.rq1_wdata = '0;
    bus_b.mem_rdata = '0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    #4;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_a();
    idle_b();

    //         r0 w0 l0  a0         d0               r1 w1 l1  a1         d1       mem_rdata          g0 g1 men mwr maddr      mwdata           v0 v1 rdata0           rdata1
    vecs[0]  = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'h0,            L, L, L, L, 32'h0,   64'h0,           L, L, 64'h0,           64'h0};
    vecs[1]  = '{H, L, L, 32'h10,  64'h0,           H, L, L, 32'h20,  64'h0, 64'h0,            H, L, H, L, 32'h10,  64'h0,           L, L, 64'h0,           64'h0};
    vecs[2]  = '{H, L, L, 32'h10,  64'h0,           H, L, L, 32'h20,  64'h0, 64'h0,            L, H, H, L, 32'h20,  64'h0,           L, L, 64'h0,           64'h0};
    vecs[3]  = '{H, L, L, 32'h10,  64'h0,           H, L, L, 32'h20,  64'h0, 64'hA1,           H, L, H, L, 32'h10,  64'h0,           H, L, 64'hA1,          64'h0};
    vecs[4]  = '{H, L, L, 32'h10,  64'h0,           H, L, L, 32'h20,  64'h0, 64'hA2,           L, H, H, L, 32'h20,  64'h0,           L, H, 64'h0,           64'hA2};
    vecs[5]  = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'hA3,           L, L, L, L, 32'h0,   64'h0,           H, L, 64'hA3,          64'h0};
    vecs[6]  = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'hA4,           L, L, L, L, 32'h0,   64'h0,           L, H, 64'h0,           64'hA4};
    vecs[7]  = '{L, L, L, 32'h0,   64'h0,           H, L, L, 32'h40,  64'h0, 64'h55,           L, H, H, L, 32'h40,  64'h0,           L, L, 64'h0,           64'h0};
    vecs[8]  = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'h77,           L, L, L, L, 32'h0,   64'h0,           L, L, 64'h0,           64'h0};
    vecs[9]  = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'hDEAD,         L, L, L, L, 32'h0,   64'h0,           L, H, 64'h0,           64'hDEAD};
    vecs[10] = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'hDEAD,         L, L, L, L, 32'h0,   64'h0,           L, L, 64'h0,           64'h0};
    vecs[11] = '{H, H, L, 32'h8,   64'h1234,        L, L, L, 32'h0,   64'h0, 64'h0,            H, L, H, H, 32'h8,   64'h1234,        L, L, 64'h0,           64'h0};
    vecs[12] = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'hBEEF,         L, L, L, L, 32'h0,   64'h0,           L, L, 64'h0,           64'h0};
    vecs[13] = '{L, L, L, 32'h0,   64'h0,           H, L, L, 32'h30,  64'h0, 64'hBEEF,         L, H, H, L, 32'h30,  64'h0,           L, L, 64'h0,           64'h0};
    vecs[14] = '{H, L, H, 32'h100, 64'h0,           H, L, L, 32'h200, 64'h0, 64'h0,            H, L, H, L, 32'h100, 64'h0,           L, L, 64'h0,           64'h0};
    vecs[15] = '{L, L, L, 32'h0,   64'h0,           H, L, L, 32'h200, 64'h0, 64'h3333,         L, L, L, L, 32'h0,   64'h0,           L, H, 64'h0,           64'h3333};
    vecs[16] = '{H, H, L, 32'h104, 64'hCAFE,        H, L, L, 32'h200, 64'h0, 64'h4444,         H, L, H, H, 32'h104, 64'hCAFE,        H, L, 64'h4444,        64'h0};
    vecs[17] = '{L, L, L, 32'h0,   64'h0,           H, L, L, 32'h200, 64'h0, 64'h0,            L, H, H, L, 32'h200, 64'h0,           L, L, 64'h0,           64'h0};
    vecs[18] = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'h9,            L, L, L, L, 32'h0,   64'h0,           L, L, 64'h0,           64'h0};
    vecs[19] = '{L, L, L, 32'h0,   64'h0,           L, L, L, 32'h0,   64'h0, 64'h5555,         L, L, L, L, 32'h0,   64'h0,           L, H, 64'h0,           64'h5555};

    // Requests asserted while reset is held: nothing may be granted or reach memory.
    next_cycle();
    bus_a.rq0_req = H; bus_a.rq1_req = H; bus_a.rq0_addr = 32'h10; bus_a.rq1_addr = 32'h20;
    bus_a.mem_rdata = 64'hFFFF;
    sample_point();
    check_bit ("rst gnt0",   bus_a.rq0_gnt,    L);
    check_bit ("rst gnt1",   bus_a.rq1_gnt,    L);
    check_bit ("rst mem_en", bus_a.mem_en,     L);
    check_word("rst addr",   {32'h0, bus_a.mem_addr}, 64'h0);
    check_bit ("rst rv0",    bus_a.rq0_rvalid, L);
    check_word("rst rdata0", bus_a.rq0_rdata,  64'h0);

    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      bus_a.rq0_req = vecs[i].r0; bus_a.rq0_wr = vecs[i].w0; bus_a.rq0_lock = vecs[i].l0;
      bus_a.rq0_addr = vecs[i].a0; bus_a.rq0_wdata = vecs[i].d0;
      bus_a.rq1_req = vecs[i].r1; bus_a.rq1_wr = vecs[i].w1; bus_a.rq1_lock = vecs[i].l1;
      bus_a.rq1_addr = vecs[i].a1; bus_a.rq1_wdata = vecs[i].d1;
      bus_a.mem_rdata = vecs[i].mrd;
      sample_point();
      check_bit ($sformatf("v%0d gnt0", i),      bus_a.rq0_gnt,    vecs[i].g0);
      check_bit ($sformatf("v%0d gnt1", i),      bus_a.rq1_gnt,    vecs[i].g1);
      check_bit ($sformatf("v%0d mem_en", i),    bus_a.mem_en,     vecs[i].men);
      check_bit ($sformatf("v%0d mem_wr_en", i), bus_a.mem_wr_en,  vecs[i].mwr);
      check_word($sformatf("v%0d mem_addr", i),  {32'h0, bus_a.mem_addr}, {32'h0, vecs[i].maddr});
      check_word($sformatf("v%0d mem_wdata", i), bus_a.mem_wdata,  vecs[i].mwd);
      check_bit ($sformatf("v%0d rvalid0", i),   bus_a.rq0_rvalid, vecs[i].v0);
      check_bit ($sformatf("v%0d rvalid1", i),   bus_a.rq1_rvalid, vecs[i].v1);
      check_word($sformatf("v%0d rdata0", i),    bus_a.rq0_rdata,  vecs[i].rd0);
      check_word($sformatf("v%0d rdata1", i),    bus_a.rq1_rdata,  vecs[i].rd1);
      next_cycle();
    end

    // Mid-operation reset: dut_a takes a lock for rq1, dut_b (latency 3) grants an rq0 read.
    idle_a();
    idle_b();
    bus_a.rq1_req = H; bus_a.rq1_lock = H; bus_a.rq1_addr = 32'h60;
    bus_b.rq0_req = H; bus_b.rq0_addr = 32'h70;
    sample_point();
    check_bit("pre-rst a gnt1", bus_a.rq1_gnt, H);
    check_bit("pre-rst b gnt0", bus_b.rq0_gnt, H);

    next_cycle();
    reset = 1'b0;
    bus_a.rq0_req = H; bus_a.rq1_req = H; bus_a.rq1_lock = L;
    bus_b.rq1_req = H; bus_b.rq1_wr = H; bus_b.rq1_addr = 32'h74; bus_b.rq1_wdata = 64'h99;
    bus_b.mem_rdata = 64'hFFFF;
    sample_point();
    check_bit ("mid-rst b gnt0",      bus_b.rq0_gnt,    L);
    check_bit ("mid-rst b gnt1",      bus_b.rq1_gnt,    L);
    check_bit ("mid-rst b mem_en",    bus_b.mem_en,     L);
    check_bit ("mid-rst b mem_wr_en", bus_b.mem_wr_en,  L);
    check_word("mid-rst b mem_addr",  {32'h0, bus_b.mem_addr}, 64'h0);
    check_word("mid-rst b mem_wdata", bus_b.mem_wdata,  64'h0);
    check_bit ("mid-rst b rvalid0",   bus_b.rq0_rvalid, L);
    check_bit ("mid-rst b rvalid1",   bus_b.rq1_rvalid, L);
    check_word("mid-rst b rdata0",    bus_b.rq0_rdata,  64'h0);
    check_bit ("mid-rst a gnt0",      bus_a.rq0_gnt,    L);
    check_bit ("mid-rst a gnt1",      bus_a.rq1_gnt,    L);

    // After release: rq0 alone on dut_a is granted because the rq1 lock was dropped.
    next_cycle();
    reset = 1'b1;
    idle_a();
    idle_b();
    bus_a.rq0_req = H; bus_a.rq0_addr = 32'h80;
    bus_b.mem_rdata = 64'hFFFF;
    sample_point();
    check_bit("post-rst a lock dropped gnt0", bus_a.rq0_gnt, H);
    check_bit("post-rst b rvalid0 c0", bus_b.rq0_rvalid, L);

    next_cycle();
    idle_a();
    for (int c = 1; c <= 3; c++) begin
      sample_point();
      check_bit($sformatf("post-rst b rvalid0 c%0d", c), bus_b.rq0_rvalid, L);
      check_bit($sformatf("post-rst b rvalid1 c%0d", c), bus_b.rq1_rvalid, L);
      next_cycle();
    end

    // First tie after reset must go to rq0.
    bus_b.rq0_req = H; bus_b.rq0_addr = 32'h10;
    bus_b.rq1_req = H; bus_b.rq1_addr = 32'h20;
    sample_point();
    check_bit ("post-rst tie b gnt0", bus_b.rq0_gnt, H);
    check_bit ("post-rst tie b gnt1", bus_b.rq1_gnt, L);
    check_word("post-rst tie b addr", {32'h0, bus_b.mem_addr}, 64'h10);

    next_cycle();
    idle_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter: RD_LATENCY, default 1, data-memory read latency in cycles (legal range 1..4).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low.
REQ-004 rq0_req  input  1  requester 0 access request; held until granted.
REQ-005 rq0_wr  input  1  requester 0 write (1) / read (0).
REQ-006 rq0_lock  input  1  requester 0 asks to keep exclusive ownership after this grant.
REQ-007 rq0_addr  input  32  requester 0 address.
REQ-008 rq0_wdata  input  64  requester 0 write data.
REQ-009 rq0_gnt  output  1  requester 0 access accepted this cycle.
REQ-010 rq0_rvalid  output  1  requester 0 read data valid.
REQ-011 rq0_rdata  output  64  requester 0 read data.
REQ-012 rq1_req, rq1_wr, rq1_lock, rq1_addr, rq1_wdata, rq1_gnt, rq1_rvalid, rq1_rdata: same directions, widths and meanings as REQ-004..REQ-011, for requester 1.
REQ-013 mem_en  output  1  data-memory enable.
REQ-014 mem_wr_en  output  1  data-memory write enable.
REQ-015 mem_addr  output  32  data-memory address.
REQ-016 mem_wdata  output  64  data-memory write data.
REQ-017 mem_rdata  input  64  data-memory read data, valid RD_LATENCY cycles after the read cycle.

Function
REQ-018 Grant is combinational: in the cycle rqN_gnt=1, mem_en=1, mem_wr_en=rqN_wr, and mem_addr/mem_wdata equal rqN_addr/rqN_wdata in the same cycle.
REQ-019 At most one grant per cycle; rq0_gnt and rq1_gnt are never both 1.
REQ-020 No grant when rqN_req=0; with no grant, mem_en, mem_wr_en, mem_addr and mem_wdata are all 0.
REQ-021 Arbitration states: OPEN, LOCK0, LOCK1.
REQ-022 OPEN, one requester active: that requester is granted.
REQ-023 OPEN, both active: round-robin; the requester not granted most recently wins; the last-granted pointer updates on every grant.
REQ-024 OPEN -> LOCKn when requester n is granted with rqn_lock=1.
REQ-025 LOCKn: only requester n can be granted; the other requester is held off (gnt=0) regardless of its req.
REQ-026 LOCKn -> OPEN on the first cycle requester n is granted with rqn_lock=0. That final access completes normally. rqn_req=0 alone does not release the lock.
REQ-027 Read tracking: each read grant pushes {valid=1, owner} into an RD_LATENCY-deep shift register. Each write grant or idle cycle pushes valid=0.
REQ-028 rqN_rvalid=1 exactly RD_LATENCY cycles after the read grant cycle, and only for the owning requester.
REQ-029 rqN_rdata=mem_rdata when rqN_rvalid=1, else 64'b0.
REQ-030 Back-to-back reads, including alternating owners, sustain one grant and one response per cycle; responses return in grant order.
REQ-031 Writes produce no rvalid.
REQ-032 A write granted in the same cycle as a pending read response does not disturb that response.

Reset
REQ-033 reset=0 at a rising edge:
- state -> OPEN
- last-granted pointer -> requester 1, so requester 0 wins the first tie
- all read-tracking entries cleared
REQ-034 While reset=0: all outputs are 0, and no grants or memory accesses occur even if requests are asserted.
REQ-035 Reset mid-operation: reads granted before reset never produce rvalid after reset is released. A held lock is dropped.

Verification
REQ-036 Both req=1 for 4 cycles, reads, addr0=0x10, addr1=0x20 -> grants alternate 0,1,0,1; mem_addr sequence 0x10,0x20,0x10,0x20.
REQ-037 RD_LATENCY=2; rq1 read of 0x40 in cycle t, mem_rdata=0xDEAD at t+2 -> rq1_rvalid=1 and rq1_rdata=0xDEAD at t+2 only; rq0_rvalid=0 throughout.
REQ-038 rq0 write, addr 0x8, wdata 0x1234, while rq1 idle -> same cycle: rq0_gnt=1, mem_en=1, mem_wr_en=1, mem_addr=0x8, mem_wdata=0x1234; no rvalid follows.
REQ-039 rq0 read with lock=1, then write with lock=0, while rq1_req=1 constantly -> rq1_gnt=0 for both cycles; rq1 granted the cycle after the unlock write.
REQ-040 RD_LATENCY=3; rq0 read granted, reset=0 asserted the next cycle for 1 cycle -> all outputs 0 during reset; rq0_rvalid never asserts; the first tie after reset is granted to rq0.
